// File: rtl/rvh_l1d_mshr_bank_if.sv
// rvh_l1d_mshr_bank_if: allocation, memory request/response and refill signals of the L1D MSHR bank
interface rvh_l1d_mshr_bank_if #(
    parameter int N_MSHR   = 4,
    parameter int N_MSHR_W = 2,
    parameter int PADDR_W  = 56,
    parameter int OFFSET_W = 6,
    parameter int LINE_W   = 512,
    parameter int TAG_W    = 8
);
    localparam int LA_W = PADDR_W - OFFSET_W;

    logic [N_MSHR-1:0]   mshr_bank_valid_o;
    logic [N_MSHR_W-1:0] mshr_id_i;
    logic                has_free_mshr_i;
    logic                alloc_valid_i;
    logic [LA_W-1:0]     alloc_line_addr_i;
    logic [TAG_W-1:0]    alloc_tag_i;
    logic                alloc_ready_o;
    logic                alloc_hit_o;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic [N_MSHR_W-1:0] mem_req_id_o;
    logic [LA_W-1:0]     mem_req_line_addr_o;
    logic                mem_resp_valid_i;
    logic [N_MSHR_W-1:0] mem_resp_id_i;
    logic [LINE_W-1:0]   mem_resp_data_i;
    logic                refill_valid_o;
    logic                refill_ready_i;
    logic [LA_W-1:0]     refill_line_addr_o;
    logic [TAG_W-1:0]    refill_tag_o;
    logic [LINE_W-1:0]   refill_data_o;

    modport master (
        output mshr_bank_valid_o, alloc_ready_o, alloc_hit_o,
        output mem_req_valid_o, mem_req_id_o, mem_req_line_addr_o,
        output refill_valid_o, refill_line_addr_o, refill_tag_o, refill_data_o,
        input  mshr_id_i, has_free_mshr_i, alloc_valid_i, alloc_line_addr_i, alloc_tag_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i, refill_ready_i
    );

    modport slave (
        input  mshr_bank_valid_o, alloc_ready_o, alloc_hit_o,
        input  mem_req_valid_o, mem_req_id_o, mem_req_line_addr_o,
        input  refill_valid_o, refill_line_addr_o, refill_tag_o, refill_data_o,
        output mshr_id_i, has_free_mshr_i, alloc_valid_i, alloc_line_addr_i, alloc_tag_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_id_i, mem_resp_data_i, refill_ready_i
    );
endinterface

// File: rtl/rvh_l1d_mshr_bank.sv
// rvh_l1d_mshr_bank: per-entry L1D miss tracking (alloc -> line-fill request -> response capture -> refill).
// Optional RVH_L1D_MSHR_PERF_CNT_EN adds a saturating full-stall cycle counter output.
module rvh_l1d_mshr_bank #(
    parameter int N_MSHR   = 4,
    parameter int N_MSHR_W = 2,
    parameter int PADDR_W  = 56,
    parameter int OFFSET_W = 6,
    parameter int LINE_W   = 512,
    parameter int TAG_W    = 8
) (
    input logic clk,
    input logic rst_n,
    rvh_l1d_mshr_bank_if.master bus
`ifdef RVH_L1D_MSHR_PERF_CNT_EN
    ,
    output logic [31:0] mshr_full_stall_cnt_o
`endif
);
    localparam int LA_W = PADDR_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FILL} state_e;

    state_e                          state_q [N_MSHR];
    state_e                          state_d [N_MSHR];
    logic [N_MSHR-1:0][LA_W-1:0]     addr_q;
    logic [N_MSHR-1:0][TAG_W-1:0]    tag_q;
    logic [N_MSHR-1:0][LINE_W-1:0]   data_q;
    logic [N_MSHR-1:0]               busy, match, in_req, in_fill;
    logic [N_MSHR_W-1:0]             req_id, fill_id;
    logic                            alloc_fire, req_fire, resp_fire, fill_fire;

    // per-entry status decode
    always_comb begin
        busy    = '0;
        match   = '0;
        in_req  = '0;
        in_fill = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            busy[i]    = state_q[i] != IDLE;
            match[i]   = busy[i] && addr_q[i] == bus.alloc_line_addr_i;
            in_req[i]  = state_q[i] == REQ;
            in_fill[i] = state_q[i] == FILL;
        end
    end

    // lowest-index entry wins both the request port and the refill port
    always_comb begin
        req_id  = '0;
        fill_id = '0;
        for (int i = N_MSHR - 1; i >= 0; i--) begin
            if (in_req[i]) req_id = N_MSHR_W'(i);
            if (in_fill[i]) fill_id = N_MSHR_W'(i);
        end
    end

    assign bus.mshr_bank_valid_o   = busy;
    assign bus.alloc_hit_o         = |match;
    assign bus.alloc_ready_o       = bus.has_free_mshr_i && !bus.alloc_hit_o;
    assign bus.mem_req_valid_o     = |in_req;
    assign bus.mem_req_id_o        = req_id;
    assign bus.mem_req_line_addr_o = addr_q[req_id];
    assign bus.refill_valid_o      = |in_fill;
    assign bus.refill_line_addr_o  = addr_q[fill_id];
    assign bus.refill_tag_o        = tag_q[fill_id];
    assign bus.refill_data_o       = data_q[fill_id];

    // each event targets an entry in a distinct state, so all four can land in one cycle
    assign alloc_fire = bus.alloc_valid_i && bus.alloc_ready_o && state_q[bus.mshr_id_i] == IDLE;
    assign req_fire   = bus.mem_req_valid_o && bus.mem_req_ready_i;
    assign resp_fire  = bus.mem_resp_valid_i && state_q[bus.mem_resp_id_i] == WAIT;
    assign fill_fire  = bus.refill_valid_o && bus.refill_ready_i;

    // next-state: IDLE -> REQ -> WAIT -> FILL -> IDLE
    always_comb begin
        for (int i = 0; i < N_MSHR; i++) state_d[i] = state_q[i];
        if (alloc_fire) state_d[bus.mshr_id_i] = REQ;
        if (req_fire) state_d[req_id] = WAIT;
        if (resp_fire) state_d[bus.mem_resp_id_i] = FILL;
        if (fill_fire) state_d[fill_id] = IDLE;
    end

    for (genvar g = 0; g < N_MSHR; g++) begin : g_entry
        // per-entry state register
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) state_q[g] <= IDLE;
            else state_q[g] <= state_d[g];
    end

    // payload capture: address/tag on allocation, line data on response
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            addr_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            if (alloc_fire) begin
                addr_q[bus.mshr_id_i] <= bus.alloc_line_addr_i;
                tag_q[bus.mshr_id_i]  <= bus.alloc_tag_i;
            end
            if (resp_fire) data_q[bus.mem_resp_id_i] <= bus.mem_resp_data_i;
        end

`ifdef RVH_L1D_MSHR_PERF_CNT_EN
    // cycles a miss waits because every entry is busy, saturating
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) mshr_full_stall_cnt_o <= '0;
        else if (bus.alloc_valid_i && !bus.has_free_mshr_i && mshr_full_stall_cnt_o != '1)
            mshr_full_stall_cnt_o <= mshr_full_stall_cnt_o + 32'd1;
`endif
endmodule

// File: doc/rvh_l1d_mshr_bank.md
# rvh_l1d_mshr_bank

Per-entry miss status holding register bank for the L1 data cache. It sits directly upstream of `rvh_l1d_mshr_alloc`: it drives the per-entry valid vector into that allocator and consumes the allocator's free-entry id and has-free flag. It accepts primary misses, issues line-fill requests to the next level, captures the returned line, and presents it to the cache refill path before freeing the entry.

## Interface
Parameters:
- `N_MSHR`, 4: number of entries; must match the allocator.
- `N_MSHR_W`, 2: `$clog2(N_MSHR)`.
- `PADDR_W`, 56: physical address width.
- `OFFSET_W`, 6: line offset width. The line address is `PADDR_W-OFFSET_W` bits wide.
- `LINE_W`, 512: cache line data width.
- `TAG_W`, 8: requester (LSU) tag width.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `mshr_bank_valid_o` out N_MSHR: per-entry busy bit, fed to the allocator.
- `mshr_id_i` in N_MSHR_W: lowest free entry id from the allocator.
- `has_free_mshr_i` in 1: at least one entry is free.
- `alloc_valid_i` in 1: a primary miss requests an entry.
- `alloc_line_addr_i` in PADDR_W-OFFSET_W: line address of the miss.
- `alloc_tag_i` in TAG_W: requester tag.
- `alloc_ready_o` out 1: the allocation is accepted this cycle.
- `alloc_hit_o` out 1: `alloc_line_addr_i` matches a busy entry (secondary miss).
- `mem_req_valid_o` out 1: line-fill request valid.
- `mem_req_ready_i` in 1: downstream accepts the request.
- `mem_req_id_o` out N_MSHR_W: entry id, used as the transaction id.
- `mem_req_line_addr_o` out PADDR_W-OFFSET_W: line address to fetch.
- `mem_resp_valid_i` in 1: fill data return; there is no backpressure.
- `mem_resp_id_i` in N_MSHR_W: entry id of the returned data.
- `mem_resp_data_i` in LINE_W: returned line.
- `refill_valid_o` out 1: a filled line is ready for the cache.
- `refill_ready_i` in 1: the cache accepts the refill.
- `refill_line_addr_o` out PADDR_W-OFFSET_W: line address of the refill.
- `refill_tag_o` out TAG_W: requester tag of the refill.
- `refill_data_o` out LINE_W: line data of the refill.

## Operation
- Each entry holds a state machine with states IDLE, REQ, WAIT, FILL, plus the line address, tag and data.
- `mshr_bank_valid_o[i]` = (state[i] != IDLE).
- `alloc_hit_o` = OR over busy entries of (line_addr[i] == `alloc_line_addr_i`). It is combinational and is generated regardless of `alloc_valid_i`.
- `alloc_ready_o` = `has_free_mshr_i` & !`alloc_hit_o`.
- On `alloc_valid_i & alloc_ready_o`, entry `mshr_id_i`: IDLE -> REQ, and it latches the address and tag.
- Request issue: the lowest-index entry in REQ drives the `mem_req_*` outputs. On `mem_req_valid_o & mem_req_ready_i` that entry moves REQ -> WAIT.
- Response: on `mem_resp_valid_i`, if entry `mem_resp_id_i` is in WAIT, it latches `mem_resp_data_i` and moves WAIT -> FILL. A response to an entry not in WAIT is dropped and leaves all state unchanged; the bench asserts this never occurs.
- Refill: the lowest-index entry in FILL drives the `refill_*` outputs. On `refill_valid_o & refill_ready_i` that entry moves FILL -> IDLE.
- Events on different entries in the same cycle are all applied: one alloc, one request handshake, one response and one refill may occur together.
- A freed entry is not reallocated in its free cycle, because the allocator still sees it as busy.
- The `*_valid_o` outputs must not depend combinationally on the matching `*_ready_i`.

## Timing
- Reset: every entry goes to IDLE, and address, tag and data clear to 0. All `*_valid_o` outputs, `mshr_bank_valid_o` and `alloc_hit_o` read 0. `alloc_ready_o` then equals `has_free_mshr_i`.
- Reset asserted mid-transaction discards all entries. A later response carrying a stale id is dropped.
- Alloc at cycle t: `mshr_bank_valid_o[id]` and `mem_req_valid_o` rise at t+1.
- A request handshake at t moves the entry to WAIT at t+1.
- A response at t raises `refill_valid_o` at t+1.
- A refill handshake at t clears the valid bit at t+1, and the entry is allocatable from t+1.
- Minimum entry lifetime is 3 cycles, with zero memory latency and ready held high.
- Full (all entries busy): `alloc_ready_o` = 0 and the allocation is held off.
- Secondary miss to a busy line: `alloc_ready_o` = 0 until that entry frees.

## Configuration
- `RVH_L1D_MSHR_PERF_CNT_EN` defined: adds output `mshr_full_stall_cnt_o`, 32 bits.
  - Increments each cycle with `alloc_valid_i & !has_free_mshr_i`.
  - Saturates at 0xFFFF_FFFF.
  - Reset value is 0.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

## Test plan
- Reset then idle: `mshr_bank_valid_o`=0000, and `mem_req_valid_o`, `refill_valid_o` and `alloc_hit_o` are all 0.
- Single miss, addr 0x1234, tag 5, with ready high and the response 2 cycles after the request:
  - request id 0 / line 0x1234 is seen one cycle after the alloc;
  - refill line 0x1234 / tag 5 / data is seen one cycle after the response;
  - valid returns to 0000.
- Four misses back-to-back with `mem_req_ready_i`=0:
  - valid goes 0001→0011→0111→1111;
  - a fifth alloc sees `alloc_ready_o`=0;
  - requests then drain in id order 0,1,2,3.
- Secondary miss to a line held by entry 2: `alloc_hit_o`=1 and `alloc_ready_o`=0. Allocation is accepted the cycle after entry 2's refill handshake.
- Out-of-order responses 3,1 with `refill_ready_i`=0: both entries are in FILL. Raising ready refills id 1 then id 3 on consecutive cycles.
- Same cycle: alloc into entry 1, request handshake on entry 0 and response to entry 3. All three transitions appear at t+1. With perf enabled, 10 full-stall cycles read count 10.
